// File: rtl/go_done_initiator.sv
// Initiator side of the go/done/ack compute handshake.
// Runs a batch of back-to-back jobs against one responder. Each job raises go,
// waits for done, returns a one-cycle ack, then waits for done to clear.
// A job whose go stays high for TIMEOUT_CYCLES cycles without done ends the
// batch and sets a sticky timeout flag.
// Outputs are decoded from the state register, so they change only on clk.
// busy covers ISSUE/ACK/DRAIN and is already low in the FINISH cycle.
module go_done_initiator #(
  parameter int NUM_JOBS_W     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NUM_JOBS_W-1:0] num_jobs,
  input  logic                  done,
  output logic                  go,
  output logic                  ack,
  output logic                  busy,
  output logic                  batch_done,
  output logic [NUM_JOBS_W-1:0] jobs_completed,
  output logic                  timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TLAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    ACK    = 3'd2,
    DRAIN  = 3'd3,
    FINISH = 3'd4
  } state_t;

  state_t                state, state_nxt;
  logic [NUM_JOBS_W-1:0] remaining, remaining_nxt;
  logic [NUM_JOBS_W-1:0] jobs_nxt;
  logic [CNT_W-1:0]      tcnt, tcnt_nxt;
  logic                  terr_nxt;

  // Completed-job count sticks at all-ones instead of wrapping.
  function automatic logic [NUM_JOBS_W-1:0] sat_inc(input logic [NUM_JOBS_W-1:0] v);
    return (&v) ? v : v + NUM_JOBS_W'(1);
  endfunction

  // Next-state, job bookkeeping and timeout counter.
  always_comb begin
    state_nxt     = state;
    remaining_nxt = remaining;
    jobs_nxt      = jobs_completed;
    tcnt_nxt      = tcnt;
    terr_nxt      = timeout_err;
    case (state)
      IDLE: begin
        tcnt_nxt = '0;
        if (start) begin
          remaining_nxt = num_jobs;
          jobs_nxt      = '0;
          terr_nxt      = 1'b0;
          state_nxt     = (num_jobs != '0) ? ISSUE : FINISH;
        end
      end
      ISSUE: begin
        // done is checked first so a reply on the last allowed cycle still counts
        if (done) begin
          jobs_nxt      = sat_inc(jobs_completed);
          remaining_nxt = remaining - NUM_JOBS_W'(1);
          tcnt_nxt      = '0;
          state_nxt     = ACK;
        end else if (tcnt == TLAST) begin
          terr_nxt  = 1'b1;
          tcnt_nxt  = '0;
          state_nxt = FINISH;
        end else begin
          tcnt_nxt = tcnt + CNT_W'(1);
        end
      end
      ACK: state_nxt = DRAIN;
      DRAIN: begin
        if (!done) begin
          tcnt_nxt  = '0;
          state_nxt = (remaining != '0) ? ISSUE : FINISH;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      jobs_completed <= '0;
      tcnt           <= '0;
      timeout_err    <= 1'b0;
    end else begin
      state          <= state_nxt;
      jobs_completed <= jobs_nxt;
      tcnt           <= tcnt_nxt;
      timeout_err    <= terr_nxt;
    end
  end

  // Remaining-job count is always reloaded on an accepted start before use.
  always_ff @(posedge clk) begin
    remaining <= remaining_nxt;
  end

  assign go         = (state == ISSUE);
  assign ack        = (state == ACK);
  assign busy       = (state == ISSUE) || (state == ACK) || (state == DRAIN);
  assign batch_done = (state == FINISH);

endmodule

// File: tb/tb_go_done_initiator.sv
// Bench for go_done_initiator: builds the expected cycle trace of each batch
// from per-job responder latency/hold figures, drives done from that trace and
// compares every output every cycle.
module tb_go_done_initiator;

  localparam int NJW = 8;
  localparam int T   = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [NJW-1:0] num_jobs;
  logic           done;
  logic           go, ack, busy, batch_done, timeout_err;
  logic [NJW-1:0] jobs_completed;

  go_done_initiator #(.NUM_JOBS_W(NJW), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .start(start), .num_jobs(num_jobs), .done(done),
    .go(go), .ack(ack), .busy(busy), .batch_done(batch_done),
    .jobs_completed(jobs_completed), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int fails = 0;

  // expected trace, one entry per cycle, cycle 0 is the start cycle
  logic [12:0] exp_q[$];
  bit          drv_done[$];
  int          job_go[16];
  int          lat[16];
  int          hold[16];
  int          prev_jobs = 0;
  bit          prev_terr = 1'b0;
  int          cur_n;
  int          batch = 0;

  function automatic logic [12:0] vec(bit g, bit a, bit b, bit bd, bit te, int j);
    return {g, a, b, bd, te, 8'(j)};
  endfunction

  function automatic void push(bit g, bit a, bit b, bit bd, bit te, int j, bit d);
    exp_q.push_back(vec(g, a, b, bd, te, j));
    drv_done.push_back(d);
  endfunction

  task automatic check(input string tag, input logic [12:0] e);
    logic [12:0] o;
    o = {go, ack, busy, batch_done, timeout_err, jobs_completed};
    total++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed go/ack/busy/bd/terr/jobs=%b required=%b", tag, o, e);
    end
  endtask

  // Expected behaviour: go from the cycle after start until done is seen
  // (at most T cycles), ack the next cycle, drain until done is low, repeat.
  task automatic build(input int n);
    int jobs;
    bit terr;
    exp_q.delete();
    drv_done.delete();
    cur_n = n;
    push(0, 0, 0, 0, prev_terr, prev_jobs, 1'($urandom_range(0, 1)));
    jobs = 0;
    terr = 0;
    for (int i = 0; i < n; i++) begin
      job_go[i] = exp_q.size();
      if (lat[i] >= T) begin
        for (int c = 0; c < T; c++) push(1, 0, 1, 0, 0, jobs, 0);
        terr = 1;
        break;
      end
      for (int c = 0; c < lat[i]; c++) push(1, 0, 1, 0, 0, jobs, 0);
      push(1, 0, 1, 0, 0, jobs, 1);
      jobs = (jobs == 255) ? 255 : jobs + 1;
      push(0, 1, 1, 0, 0, jobs, 1);
      for (int c = 0; c < hold[i]; c++) push(0, 0, 1, 0, 0, jobs, 1);
      push(0, 0, 1, 0, 0, jobs, 0);
    end
    push(0, 0, 0, 1, terr, jobs, 0);
    prev_jobs = jobs;
    prev_terr = terr;
  endtask

  // Plays the trace; cut >= 0 asserts rst during that cycle and stops there.
  task automatic run(input int cut);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(posedge clk); #1;
      start    = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      num_jobs = (k == 0) ? 8'(cur_n) : 8'($urandom);
      done     = drv_done[k];
      rst      = (k == cut);
      @(negedge clk);
      check($sformatf("b%0d_c%0d", batch, k), exp_q[k]);
      if (k == cut) break;
    end
    if (cut >= 0) begin
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0; done = 1'b0;
      @(negedge clk);
      check($sformatf("b%0d_after_rst", batch), vec(0, 0, 0, 0, 0, 0));
      prev_jobs = 0;
      prev_terr = 0;
    end
    batch++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      start    = 1'b0;
      num_jobs = 8'($urandom);
      done     = 1'($urandom_range(0, 1));
      @(negedge clk);
      check($sformatf("idle_b%0d_c%0d", batch, k), vec(0, 0, 0, 0, prev_terr, prev_jobs));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; done = 1'b0; num_jobs = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset", vec(0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst = 1'b0;
    idle(2);

    // three jobs, done four cycles after go
    for (int i = 0; i < 3; i++) begin lat[i] = 4; hold[i] = 0; end
    build(3); run(-1); idle(2);

    // empty batch
    build(0); run(-1); idle(2);

    // responder never answers
    lat[0] = T + 5; hold[0] = 0; lat[1] = 1; hold[1] = 0;
    build(2); run(-1); idle(3);

    // next start clears the error
    lat[0] = 2; hold[0] = 0;
    build(1); run(-1); idle(2);

    // done held after ack
    lat[0] = 1; hold[0] = 3; lat[1] = 0; hold[1] = 3;
    build(2); run(-1); idle(2);

    // done on the last allowed cycle
    lat[0] = T - 1; hold[0] = 1; lat[1] = T - 1; hold[1] = 0;
    build(2); run(-1); idle(2);

    // reset while go is high on job 2 of 5
    for (int i = 0; i < 5; i++) begin
      lat[i]  = int'($urandom_range(1, T - 2));
      hold[i] = int'($urandom_range(0, 3));
    end
    build(5); run(job_go[1] + int'($urandom_range(0, 1))); idle(2);

    // random batches
    for (int b = 0; b < 10; b++) begin
      for (int i = 0; i < 8; i++) begin
        lat[i]  = int'($urandom_range(0, T + 2));
        hold[i] = int'($urandom_range(0, 4));
      end
      build(int'($urandom_range(0, 8)));
      run(-1);
      idle(int'($urandom_range(1, 3)));
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
